// File: rtl/lector_destinos.sv
// Read-side consumer for the D0/D1 destination FIFOs: round-robin pops, one
// tagged valid/ready output stream, per-destination delivery counters and sticky read errors.
module lector_destinos #(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic          D0_error_output,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_dest,
    output logic [CW-1:0] cnt_D0,
    output logic [CW-1:0] cnt_D1,
    output logic [1:0]    err_rd,
    output logic          idle_out,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t state;
    logic   last_grant;
    logic   slot_free;
    logic   elig0;
    logic   elig1;
    logic   grant0;
    logic   grant1;
    logic   issue;

    // Output stream: a word is transferred on every rising edge where
    // out_valid && out_ready; while out_ready is low out_data/out_dest hold.
    assign slot_free = !out_valid || out_ready;
    assign elig0     = !D0_empty && !err_rd[0] && !D0_error_output;
    assign elig1     = !D1_empty && !err_rd[1] && !D1_error_output;
    // last_grant = 1 means D1 was served last, so D0 wins a tie.
    assign grant1    = elig1 && (!elig0 || !last_grant);
    assign grant0    = elig0 && !grant1;
    // A pop is only issued when the output slot frees up on the same edge,
    // so the word coming back next cycle always has somewhere to land.
    assign issue     = reset_L && !init && (state == IDLE) && slot_free;
    assign D0_rd     = issue && grant0;
    assign D1_rd     = issue && grant1;

    assign idle_out  = (state == IDLE) && !out_valid && D0_empty && D1_empty;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_dest   <= 1'b0;
            cnt_D0     <= '0;
            cnt_D1     <= '0;
            err_rd     <= 2'b00;
            last_grant <= 1'b1;
        end else if (init) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            cnt_D0     <= '0;
            cnt_D1     <= '0;
            err_rd     <= 2'b00;
            last_grant <= 1'b1;
        end else begin
            err_rd <= err_rd | {D1_error_output, D0_error_output};

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (out_dest) begin
                    cnt_D1 <= cnt_D1 + CNT_ONE;
                end else begin
                    cnt_D0 <= cnt_D0 + CNT_ONE;
                end
            end

            // A capture below overrides the clear above on a shared edge.
            case (state)
                IDLE: begin
                    if (D0_rd) begin
                        state      <= RD0;
                        last_grant <= 1'b0;
                    end else if (D1_rd) begin
                        state      <= RD1;
                        last_grant <= 1'b1;
                    end
                end
                RD0: begin
                    out_data  <= D0_data_out;
                    out_dest  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                RD1: begin
                    out_data  <= D1_data_out;
                    out_dest  <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
